// File: rtl/spram_be_clr_if.sv
// ----------------------------------------------------------------------------
// spram_be_clr_if
// Access bus for the spram_be_clr single-port RAM.
//   master : drives en/we/be/addr/din/clr, observes dout/dvalid/busy
//   slave  : the RAM side of the same signals
// Signals:
//   en     access request          we     write qualifier (0 = read)
//   be     lane write enables      addr   word address
//   din    write data              clr    start full-memory clear (pulse)
//   dout   read data               dvalid one-cycle read-data strobe
//   busy   clear engine active
// ----------------------------------------------------------------------------
interface spram_be_clr_if #(
    parameter int unsigned DATA = 16,
    parameter int unsigned ADDR = 5,
    parameter int unsigned LANE = 8
);
    localparam int unsigned NBE = DATA / LANE;

    logic            en;
    logic            we;
    logic [NBE-1:0]  be;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] din;
    logic            clr;
    logic [DATA-1:0] dout;
    logic            dvalid;
    logic            busy;

    modport master (
        output en, we, be, addr, din, clr,
        input  dout, dvalid, busy
    );

    modport slave (
        input  en, we, be, addr, din, clr,
        output dout, dvalid, busy
    );
endinterface

// File: rtl/spram_be_clr.sv
// ----------------------------------------------------------------------------
// spram_be_clr
// Single-port synchronous RAM with per-lane byte write enables, selectable
// read-during-write behaviour, optional output register and a clear engine
// that sweeps the whole array to zero (on request, and optionally after reset).
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset (pipeline + FSM only, not the array)
//   bus    spram_be_clr_if slave: en/we/be/addr/din/clr in, dout/dvalid/busy out
// Parameters:
//   DATA word width, ADDR address width, LANE bits per enable lane,
//   RDW_MODE 0 read-first / 1 write-first / 2 no-change,
//   OUT_REG adds a second output stage, CLR_ON_RST sweeps after reset.
// ----------------------------------------------------------------------------
module spram_be_clr #(
    parameter int unsigned DATA       = 16,
    parameter int unsigned ADDR       = 5,
    parameter int unsigned LANE       = 8,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned CLR_ON_RST = 1
) (
    input logic           i_clk,
    input logic           i_rst,
    spram_be_clr_if.slave bus
);
    localparam int unsigned NBE   = DATA / LANE;
    localparam int unsigned DEPTH = 1 << ADDR;

    // Elaboration-time parameter sanity.
    if ((DATA % LANE) != 0) begin : g_bad_lane
        $error("DATA must be a multiple of LANE");
    end
    if (RDW_MODE > 2) begin : g_bad_rdw
        $error("RDW_MODE must be 0, 1 or 2");
    end

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [ADDR-1:0] r_cnt;
    logic [ADDR-1:0] w_cnt_next;

    logic [DATA-1:0] r_mem [DEPTH];

    logic            w_busy;
    logic            w_acc;
    logic [DATA-1:0] w_old;
    logic [DATA-1:0] w_merged;
    logic            w_rd_fire;
    logic [DATA-1:0] w_rd_data;

    logic [DATA-1:0] r_dout1;
    logic            r_dv1;

    assign w_busy = (r_state == StClear);
    // The array has no reset, so gate accesses while reset is held to keep
    // its contents untouched by reset itself.
    assign w_acc  = bus.en & ~w_busy & ~i_rst;
    assign w_old  = r_mem[bus.addr];

    // Old word with the enabled lanes replaced by din.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < int'(NBE); i++) begin
            if (bus.be[i]) begin
                w_merged[i*LANE +: LANE] = bus.din[i*LANE +: LANE];
            end
        end
    end

    // Which accepted accesses produce a result, and what data it carries.
    always_comb begin
        w_rd_fire = 1'b0;
        w_rd_data = w_old;
        if (w_acc) begin
            if (!bus.we) begin
                w_rd_fire = 1'b1;
            end else if (RDW_MODE == 0) begin
                w_rd_fire = 1'b1;
            end else if (RDW_MODE == 1) begin
                w_rd_fire = 1'b1;
                w_rd_data = w_merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Array: clear sweep has priority; user writes only when idle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_busy) begin
                r_mem[r_cnt] <= '0;
            end else if (w_acc && bus.we) begin
                r_mem[bus.addr] <= w_merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Clear engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= (CLR_ON_RST != 0) ? StClear : StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StIdle: begin
                if (bus.clr) begin
                    w_state_next = StClear;
                    w_cnt_next   = '0;
                end
            end
            StClear: begin
                w_cnt_next = r_cnt + 1'b1;
                // Leave after the write to the top address.
                if (&r_cnt) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output pipeline: dout only moves on a valid result, otherwise holds.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dout1 <= '0;
            r_dv1   <= 1'b0;
        end else begin
            r_dv1 <= w_rd_fire;
            if (w_rd_fire) begin
                r_dout1 <= w_rd_data;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA-1:0] r_dout2;
        logic            r_dv2;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_dout2 <= '0;
                r_dv2   <= 1'b0;
            end else begin
                r_dv2 <= r_dv1;
                if (r_dv1) begin
                    r_dout2 <= r_dout1;
                end
            end
        end

        assign bus.dout   = r_dout2;
        assign bus.dvalid = r_dv2;
    end else begin : g_noreg
        assign bus.dout   = r_dout1;
        assign bus.dvalid = r_dv1;
    end

    assign bus.busy = w_busy;

endmodule
